// File: rtl/operand_fetch_pkg.sv
// Shared widths, operand-select encodings and ALU op codes for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;
  localparam int NUM_REGS = 1 << REG_AW;

  // Operand A source
  localparam logic SRCA_RS = 1'b0;
  localparam logic SRCA_SA = 1'b1;

  // Operand B source
  localparam logic SRCB_RT  = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

  // Immediate extension mode
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_XNOR = 3'b111
  } alu_op_e;

  // Widen the 16-bit immediate to the datapath width.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic             ext_sel);
    if (ext_sel == EXT_SIGN) return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    else                     return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_register_file.sv
// 32 x 32 register file: one write port, two combinational read ports with write bypass.
// Register 0 is hardwired to zero.
module register_file
  import operand_fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [REG_AW-1:0] rd_a_addr_i,
  input  logic [REG_AW-1:0] rd_b_addr_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  output logic [DATA_W-1:0] rd_b_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_live;

  assign wr_live = wb_en_i && (wb_addr_i != '0);

  // Write port; reset clears every entry.
  // NOTE: the array is reset explicitly because a post-reset read of any register must return 0;
  // this costs a reset mux per flop, so it is done only where behaviour depends on it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Read ports: r0 forced to zero, then same-cycle write bypass, then stored value.
  assign rd_a_data_o = (rd_a_addr_i == '0)                    ? '0        :
                       (wr_live && (wb_addr_i == rd_a_addr_i)) ? wb_data_i :
                                                                 regs_q[rd_a_addr_i];
  assign rd_b_data_o = (rd_b_addr_i == '0)                    ? '0        :
                       (wr_live && (wb_addr_i == rd_b_addr_i)) ? wb_data_i :
                                                                 regs_q[rd_b_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, selects ALU operands and
// holds them in a single valid/ready output register.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [IMM_W-1:0]  imm,
  input  logic [REG_AW-1:0] sa,
  input  logic              ALUSrcA,
  input  logic              ALUSrcB,
  input  logic              ExtSel,
  input  logic [2:0]        ALUOp_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        ALUOp,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] rs_rd, rt_rd;
  logic [DATA_W-1:0] a_d, b_d;
  logic [DATA_W-1:0] a_q, b_q, rt_data_q;
  logic [2:0]        alu_op_q;
  logic              out_valid_q;
  logic              accept;

  register_file u_regfile (
    .clk_i       (CLK),
    .rst_i       (RST),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .rd_a_addr_i (rs_addr),
    .rd_a_data_o (rs_rd),
    .rd_b_addr_i (rt_addr),
    .rd_b_data_o (rt_rd)
  );

  // The output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand selection from the bypassed read data.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_d = rs_rd;
    b_d = rt_rd;
    if (ALUSrcA == SRCA_SA) a_d = {{(DATA_W-REG_AW){1'b0}}, sa};
    if (ALUSrcB == SRCB_IMM) b_d = ext_imm(imm, ExtSel);
  end

  // Output register: load on accept, drain on out_ready, otherwise hold.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rt_data_q   <= '0;
      alu_op_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a_q         <= a_d;
      b_q         <= b_d;
      rt_data_q   <= rt_rd;
      alu_op_q    <= ALUOp_in;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign rt_data   = rt_data_q;
  assign ALUOp     = alu_op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr, rt_addr, sa, wb_addr;
  logic [15:0] imm;
  logic        ALUSrcA, ALUSrcB, ExtSel, wb_en, out_valid, out_ready;
  logic [2:0]  ALUOp_in, ALUOp;
  logic [31:0] wb_data, A, B, rt_data;

  int checks   = 0;
  int failures = 0;

  operand_fetch dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .imm       (imm),
    .sa        (sa),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .ALUOp_in  (ALUOp_in),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOp     (ALUOp),
    .A         (A),
    .B         (B),
    .rt_data   (rt_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0; sa = 0;
    ALUSrcA = 0; ALUSrcB = 0; ExtSel = 0; ALUOp_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    step(); step();
    RST = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_rt_data", rt_data, 32'd0);
    check("rst_ALUOp", {29'b0, ALUOp}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Write r5 = 0x1234
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000_1234;
    step();
    wb_en = 0;

    // Sign-extended immediate on B, rs on A
    in_valid = 1; out_ready = 1; rs_addr = 5; rt_addr = 5;
    ALUSrcA = 0; ALUSrcB = 1; ExtSel = 1; imm = 16'hFFFE; ALUOp_in = 3'b001;
    step();
    check("sext_out_valid", {31'b0, out_valid}, 32'd1);
    check("sext_A", A, 32'h0000_1234);
    check("sext_B", B, 32'hFFFF_FFFE);
    check("sext_rt_data", rt_data, 32'h0000_1234);
    check("sext_ALUOp", {29'b0, ALUOp}, 32'd1);

    // Back-to-back: zero extension
    ExtSel = 0; ALUOp_in = 3'b010;
    step();
    check("zext_out_valid", {31'b0, out_valid}, 32'd1);
    check("zext_B", B, 32'h0000_FFFE);
    check("zext_ALUOp", {29'b0, ALUOp}, 32'd2);

    // Back-to-back: shift amount on A
    ALUSrcA = 1; sa = 5'd31; ExtSel = 1; ALUOp_in = 3'b011;
    step();
    check("sa_A", A, 32'h0000_001F);
    check("sa_B", B, 32'hFFFF_FFFE);
    check("sa_out_valid", {31'b0, out_valid}, 32'd1);

    // No accept with out_ready=1 drains; output data holds
    in_valid = 0;
    step();
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("drain_A_hold", A, 32'h0000_001F);

    // Write to r0 is ignored
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF;
    step();
    wb_en = 0;
    in_valid = 1; rs_addr = 0; rt_addr = 0; ALUSrcA = 0; ALUSrcB = 0;
    step();
    check("r0_A", A, 32'd0);
    check("r0_rt_data", rt_data, 32'd0);

    // Write-back bypass in the accept cycle
    rs_addr = 7; rt_addr = 7; wb_en = 1; wb_addr = 7; wb_data = 32'hAAAA_5555; ALUOp_in = 3'b100;
    step();
    wb_en = 0;
    check("byp_A", A, 32'hAAAA_5555);
    check("byp_B", B, 32'hAAAA_5555);
    check("byp_rt_data", rt_data, 32'hAAAA_5555);

    // Stall: out_ready=0 for 3 cycles with a new instruction pending
    out_ready = 0; rs_addr = 5; rt_addr = 0; ALUOp_in = 3'b111;
    #1;
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wb_en = (i == 1); wb_addr = 9; wb_data = 32'h0000_9999;
      step();
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_A", A, 32'hAAAA_5555);
      check("stall_ALUOp", {29'b0, ALUOp}, 32'd4);
      check("stall_in_ready_hold", {31'b0, in_ready}, 32'd0);
    end
    wb_en = 0;
    out_ready = 1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("release_A", A, 32'h0000_1234);
    check("release_ALUOp", {29'b0, ALUOp}, 32'd7);
    check("release_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 0;
    step();
    check("release_no_dup", {31'b0, out_valid}, 32'd0);

    // Write-back during the stall reached the array; earlier r7 write persisted
    in_valid = 1; rs_addr = 9; rt_addr = 7;
    step();
    check("stall_wb_r9", A, 32'h0000_9999);
    check("r7_persist", rt_data, 32'hAAAA_5555);

    // Reset with out_valid=1, a pending instruction and a pending write
    out_ready = 0;
    step();
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    RST = 1; wb_en = 1; wb_addr = 5; wb_data = 32'hFFFF_FFFF; in_valid = 1; rs_addr = 5;
    step();
    RST = 0; wb_en = 0; in_valid = 0;
    #1;
    check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_A", A, 32'd0);
    check("rst2_B", B, 32'd0);
    check("rst2_rt_data", rt_data, 32'd0);
    check("rst2_ALUOp", {29'b0, ALUOp}, 32'd0);
    check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1; out_ready = 1; rs_addr = 5; rt_addr = 7; ALUSrcA = 0; ALUSrcB = 0;
    step();
    check("rst2_r5", A, 32'd0);
    check("rst2_r7", rt_data, 32'd0);
    rs_addr = 9;
    step();
    check("rst2_r9", A, 32'd0);
    in_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
